// File: rtl/data_ram.sv
// Word-organised data RAM with byte-lane enables, a programmable number of wait
// states before each access, and a single-request IDLE/WAIT/RESP handshake.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready=1; a request with ce=1 is latched on the next rising edge
// WAIT  | wait-state countdown; the access happens on the edge at count 0
// RESP  | ack=1 for one cycle with data_o/err; always returns to IDLE
module data_ram #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned DEPTH       = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic        ack,
    output logic        err,
    output logic [31:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0] mem_rd;
    logic [31:0] lane_mask;
    logic [31:0] mem_wmerged;
    logic        mem_we;

    assign idx       = addr_q[2 +: AW];
    assign mem_rd    = mem[idx];
    assign lane_mask = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
    assign mem_wmerged = (wdata_q & lane_mask) | (mem_rd & ~lane_mask);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ce) begin
                    we_d    = we;
                    addr_d  = addr;
                    sel_d   = sel;
                    wdata_d = data_i;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    // misaligned requests complete with err and never touch the array
                    if (addr_q[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else if (we_q) begin
                        mem_we = |sel_q;
                    end else begin
                        rdata_d = mem_rd & lane_mask;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // array contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= mem_wmerged;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign ack    = (state_q == ST_RESP);
    assign err    = err_q;
    assign data_o = rdata_q;

endmodule
